// File: rtl/fetch_unit.sv
// Instruction fetch stage feeding the NBBPU datapath.
// Fetches a 16-bit instruction as two byte reads from a byte-wide memory.
// The bytes are assembled little-endian: low byte at PC, high byte at PC+1.
//
// Memory handshake: in LOW and HIGH the unit holds mem_read=1 with a stable
// mem_addr. A byte is taken on any rising edge where mem_ready=1. mem_ready
// is ignored whenever mem_read=0, which is the case in IDLE and DONE.
// There is no back-pressure on instr_valid. It is a one-cycle pulse, and the
// instruction register holds its value until the next fetch writes it.
module fetch_unit #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] PC,
  input  logic                  fetch_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_read,
  input  logic                  mem_ready,
  input  logic [7:0]            mem_rdata,
  output logic [15:0]           instruction,
  output logic                  instr_valid,
  output logic                  busy,
  output logic                  misaligned,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [ADDR_WIDTH-1:0]   addr_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_d;
  logic                    mem_read_d;
  logic [15:0]             instruction_d;
  logic                    instr_valid_d;
  logic                    busy_d;
  logic                    misaligned_d;
  logic                    can_accept;
  logic                    accept_aligned;
  logic                    accept_misaligned;

  // A new request is only looked at when no fetch is in flight.
  assign can_accept        = (state_q == S_IDLE) || (state_q == S_DONE);
  assign accept_aligned    = can_accept && fetch_req && !PC[0];
  assign accept_misaligned = can_accept && fetch_req &&  PC[0];

  assign state_dbg = state_q;

  // State register; reset aborts any fetch in progress.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode: accept from IDLE/DONE, advance on mem_ready.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept_aligned) begin
          state_d = S_LOW;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOW: begin
        if (mem_ready) begin
          state_d = S_HIGH;
        end
      end
      S_HIGH: begin
        if (mem_ready) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: next values of all registered outputs, from state_d.
  always_comb begin
    addr_d        = addr_reg;
    mem_addr_d    = mem_addr;
    mem_read_d    = 1'b0;
    instruction_d = instruction;
    busy_d        = 1'b0;
    instr_valid_d = 1'b0;
    misaligned_d  = accept_misaligned;

    // PC is captured only on acceptance, so PC moving mid-fetch is harmless.
    if (accept_aligned) begin
      addr_d = PC;
    end

    // Bytes land in the instruction register as they arrive.
    if ((state_q == S_LOW) && mem_ready) begin
      instruction_d[7:0] = mem_rdata;
    end
    if ((state_q == S_HIGH) && mem_ready) begin
      instruction_d[15:8] = mem_rdata;
    end

    case (state_d)
      S_LOW: begin
        mem_read_d = 1'b1;
        mem_addr_d = addr_d;
        busy_d     = 1'b1;
      end
      S_HIGH: begin
        mem_read_d = 1'b1;
        // Wraps naturally at the top of the address space.
        mem_addr_d = addr_d + ADDR_WIDTH'(1);
        busy_d     = 1'b1;
      end
      S_DONE: begin
        instr_valid_d = 1'b1;
      end
      default: begin
        mem_read_d = 1'b0;
      end
    endcase
  end

  // Output and datapath registers; mem_addr holds its value while idle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      addr_reg    <= '0;
      mem_addr    <= '0;
      mem_read    <= 1'b0;
      instruction <= 16'h0000;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
      misaligned  <= 1'b0;
    end else begin
      addr_reg    <= addr_d;
      mem_addr    <= mem_addr_d;
      mem_read    <= mem_read_d;
      instruction <= instruction_d;
      instr_valid <= instr_valid_d;
      busy        <= busy_d;
      misaligned  <= misaligned_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. A byte memory model answers reads
// combinationally. The stimulus pushes each expected instruction into a
// queue when the fetch is issued, and a monitor pops and compares the queue
// on every instr_valid pulse.
module tb_fetch_unit;

  localparam int AW = 16;

  logic          clock;
  logic          reset;
  logic [AW-1:0] pc;
  logic          fetch_req;
  logic [AW-1:0] mem_addr;
  logic          mem_read;
  logic          mem_ready;
  logic [7:0]    mem_rdata;
  logic [15:0]   instruction;
  logic          instr_valid;
  logic          busy;
  logic          misaligned;
  logic [1:0]    state_dbg;

  logic [7:0]    mem [0:65535];
  logic [15:0]   exp_q[$];
  logic [15:0]   exp_instr;
  int            n_vec;
  int            n_err;

  fetch_unit #(.ADDR_WIDTH(AW)) dut (
    .clock       (clock),
    .reset       (reset),
    .PC          (pc),
    .fetch_req   (fetch_req),
    .mem_addr    (mem_addr),
    .mem_read    (mem_read),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .busy        (busy),
    .misaligned  (misaligned),
    .state_dbg   (state_dbg)
  );

  assign mem_rdata = mem[mem_addr];

  // clock / reset block
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive after the edge, observe after the edge: both at posedge + 1.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_outs(input string tag, input logic exp_busy, input logic exp_read,
                             input logic [AW-1:0] exp_addr, input logic exp_valid);
    check({tag, "_busy"},  {31'b0, busy},        {31'b0, exp_busy});
    check({tag, "_read"},  {31'b0, mem_read},    {31'b0, exp_read});
    check({tag, "_addr"},  {16'b0, mem_addr},    {16'b0, exp_addr});
    check({tag, "_valid"}, {31'b0, instr_valid}, {31'b0, exp_valid});
  endtask

  // scoreboard monitor: every instr_valid pulse consumes one expected value
  always @(negedge clock) begin
    if (reset === 1'b1 && instr_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", {31'b0, instr_valid}, 32'd0);
      end else begin
        exp_instr = exp_q.pop_front();
        check("instr_sb", {16'b0, instruction}, {16'b0, exp_instr});
      end
    end
  end

  initial begin
    logic ready_pat [1:7];
    int   cyc;

    n_vec = 0;
    n_err = 0;
    mem[16'h0010] = 8'h34;  mem[16'h0011] = 8'h12;
    mem[16'h0100] = 8'hCD;  mem[16'h0101] = 8'hAB;
    mem[16'h0000] = 8'h11;  mem[16'h0001] = 8'h22;
    mem[16'h0002] = 8'h33;  mem[16'h0003] = 8'h44;
    mem[16'hFFFE] = 8'h78;  mem[16'hFFFF] = 8'h56;
    mem[16'h0200] = 8'hEE;  mem[16'h0201] = 8'hEE;
    mem[16'h0080] = 8'hEE;  mem[16'h0081] = 8'hEE;

    // reset held with a request and ready present
    reset     = 1'b0;
    fetch_req = 1'b1;
    mem_ready = 1'b1;
    pc        = 16'h0010;
    tick();
    tick();
    expect_outs("rst", 1'b0, 1'b0, 16'h0000, 1'b0);
    check("rst_instr", {16'b0, instruction}, 32'h0);
    check("rst_misaligned", {31'b0, misaligned}, 32'h0);
    check("rst_state", {30'b0, state_dbg}, 32'h0);
    reset     = 1'b1;
    fetch_req = 1'b0;
    tick();
    expect_outs("idle", 1'b0, 1'b0, 16'h0000, 1'b0);

    // zero-wait fetch
    pc        = 16'h0010;
    fetch_req = 1'b1;
    exp_q.push_back(16'h1234);
    tick();
    fetch_req = 1'b0;
    expect_outs("zw_c1", 1'b1, 1'b1, 16'h0010, 1'b0);
    tick();
    expect_outs("zw_c2", 1'b1, 1'b1, 16'h0011, 1'b0);
    tick();
    expect_outs("zw_c3", 1'b0, 1'b0, 16'h0011, 1'b1);
    tick();
    expect_outs("zw_c4", 1'b0, 1'b0, 16'h0011, 1'b0);

    // wait states: 2 in LOW, 3 in HIGH; PC moves while busy
    ready_pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    pc        = 16'h0100;
    fetch_req = 1'b1;
    mem_ready = 1'b0;
    exp_q.push_back(16'hABCD);
    tick();
    fetch_req = 1'b0;
    pc        = 16'h0200;
    expect_outs("ws_c1", 1'b1, 1'b1, 16'h0100, 1'b0);
    for (int c = 1; c <= 7; c++) begin
      mem_ready = ready_pat[c];
      tick();
      cyc = c + 1;
      expect_outs($sformatf("ws_c%0d", cyc), cyc <= 7, cyc <= 7,
                  (cyc <= 3) ? 16'h0100 : 16'h0101, cyc == 8);
    end
    mem_ready = 1'b1;

    // misaligned requests: no memory access, instruction retained
    pc        = 16'h0003;
    fetch_req = 1'b1;
    tick();
    check("mis_pulse", {31'b0, misaligned}, 32'h1);
    expect_outs("mis", 1'b0, 1'b0, 16'h0101, 1'b0);
    check("mis_instr", {16'b0, instruction}, 32'hABCD);
    pc = 16'hFFFF;
    tick();
    check("mis_ffff_pulse", {31'b0, misaligned}, 32'h1);
    check("mis_ffff_read", {31'b0, mem_read}, 32'h0);
    fetch_req = 1'b0;
    tick();
    check("mis_end", {31'b0, misaligned}, 32'h0);
    check("mis_instr2", {16'b0, instruction}, 32'hABCD);

    // back-to-back with fetch_req held high
    pc        = 16'h0000;
    fetch_req = 1'b1;
    exp_q.push_back(16'h2211);
    exp_q.push_back(16'h4433);
    tick();
    pc = 16'h0080;
    expect_outs("b2b_a1", 1'b1, 1'b1, 16'h0000, 1'b0);
    tick();
    expect_outs("b2b_a2", 1'b1, 1'b1, 16'h0001, 1'b0);
    tick();
    expect_outs("b2b_a3", 1'b0, 1'b0, 16'h0001, 1'b1);
    pc = 16'h0002;
    tick();
    pc = 16'h0090;
    expect_outs("b2b_b1", 1'b1, 1'b1, 16'h0002, 1'b0);
    tick();
    expect_outs("b2b_b2", 1'b1, 1'b1, 16'h0003, 1'b0);
    tick();
    fetch_req = 1'b0;
    expect_outs("b2b_b3", 1'b0, 1'b0, 16'h0003, 1'b1);
    tick();
    expect_outs("b2b_end", 1'b0, 1'b0, 16'h0003, 1'b0);

    // reset while in HIGH
    pc        = 16'h0010;
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    tick();
    check("mid_state_high", {30'b0, state_dbg}, 32'h2);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    expect_outs("mid_rst", 1'b0, 1'b0, 16'h0000, 1'b0);
    check("mid_rst_instr", {16'b0, instruction}, 32'h0);
    check("mid_rst_state", {30'b0, state_dbg}, 32'h0);
    tick();
    expect_outs("mid_idle", 1'b0, 1'b0, 16'h0000, 1'b0);

    // wrap at the top of the address space
    pc        = 16'hFFFE;
    fetch_req = 1'b1;
    exp_q.push_back(16'h5678);
    tick();
    fetch_req = 1'b0;
    expect_outs("wrap_c1", 1'b1, 1'b1, 16'hFFFE, 1'b0);
    tick();
    expect_outs("wrap_c2", 1'b1, 1'b1, 16'hFFFF, 1'b0);
    tick();
    expect_outs("wrap_c3", 1'b0, 1'b0, 16'hFFFF, 1'b1);
    tick();
    tick();

    check("sb_drained", exp_q.size(), 32'd0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
